// File: rtl/mtsp_wb_collector.sv
// mtsp_wb_collector
//   Receives up to two write-back results per cycle from the EX stage. Phase #0
//   is DEST0/WMASK0 and phase #1 is DEST1/WMASK1. Results are queued in
//   program order and drained through a single register-file write port that
//   has its own grant.
//
// Ports
//   CLK, RST               clock, synchronous active-high reset
//   WMASK0/ADDR0/DEST0     phase #0 result (valid, destination, data)
//   WMASK1/ADDR1/DEST1     phase #1 result (valid, destination, data)
//   IN_STALL               fewer than 2 free entries; upstream must hold
//   RF_READY               register-file port grant
//   RF_WE/RF_ADDR/RF_DATA  head-of-queue write request (first-word-fall-through)
//   LEVEL                  number of occupied entries
//   Q_ADDR/Q_HIT           hazard query: some stored entry targets Q_ADDR
//   OVERFLOW               sticky: a valid input was dropped
module mtsp_wb_collector #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       WMASK0,
    input  logic [ADDR_WIDTH-1:0]      ADDR0,
    input  logic [DATA_WIDTH-1:0]      DEST0,
    input  logic                       WMASK1,
    input  logic [ADDR_WIDTH-1:0]      ADDR1,
    input  logic [DATA_WIDTH-1:0]      DEST1,
    output logic                       IN_STALL,
    input  logic                       RF_READY,
    output logic                       RF_WE,
    output logic [ADDR_WIDTH-1:0]      RF_ADDR,
    output logic [DATA_WIDTH-1:0]      RF_DATA,
    output logic [$clog2(DEPTH):0]     LEVEL,
    input  logic [ADDR_WIDTH-1:0]      Q_ADDR,
    output logic                       Q_HIT,
    output logic                       OVERFLOW
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [PW-1:0]         rptr_reg;
    logic [PW-1:0]         wptr_reg;
    logic [LW-1:0]         level_reg;
    logic                  overflow_reg;

    logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];

    logic                  pop;
    logic [LW-1:0]         free_cnt;
    logic                  acc0;
    logic                  acc1;
    logic                  drop;
    logic [LW-1:0]         push_cnt;
    logic [PW-1:0]         wptr1;
    logic [PW-1:0]         rptr_next;
    logic [PW-1:0]         wptr_next;
    logic [LW-1:0]         level_next;
    logic [DEPTH-1:0]      hit_vec;

    // A pop frees its slot in the same cycle, so a full queue can still take
    // one entry while it is draining.
    always_comb begin
        pop      = (level_reg != '0) && RF_READY;
        free_cnt = LW'(DEPTH) - level_reg + {{(LW-1){1'b0}}, pop};
        // Phase #0 has priority for space; phase #1 needs a second free slot
        // when phase #0 was accepted. Excess is therefore dropped phase #1 first.
        acc0     = WMASK0 && (free_cnt != '0);
        acc1     = WMASK1 && (acc0 ? (free_cnt >= LW'(2)) : (free_cnt != '0));
        drop     = (WMASK0 && !acc0) || (WMASK1 && !acc1);
        push_cnt = {{(LW-1){1'b0}}, acc0} + {{(LW-1){1'b0}}, acc1};
        // Phase #1 lands right after phase #0, or at wptr when it is alone.
        wptr1      = acc0 ? (wptr_reg + PW'(1)) : wptr_reg;
        wptr_next  = wptr_reg + push_cnt[PW-1:0];
        rptr_next  = rptr_reg + {{(PW-1){1'b0}}, pop};
        level_next = level_reg + push_cnt - {{(LW-1){1'b0}}, pop};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rptr_reg     <= '0;
            wptr_reg     <= '0;
            level_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            rptr_reg  <= rptr_next;
            wptr_reg  <= wptr_next;
            level_reg <= level_next;
            if (drop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // Storage needs no reset; occupancy alone decides which entries are live.
    // The two write slots never coincide, so both writes can share one block.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (acc0) begin
                addr_mem[wptr_reg] <= ADDR0;
                data_mem[wptr_reg] <= DEST0;
            end
            if (acc1) begin
                addr_mem[wptr1] <= ADDR1;
                data_mem[wptr1] <= DEST1;
            end
        end
    end

    // Hazard query over stored entries only. An entry is live when its
    // distance from rptr (mod DEPTH) is below the current level.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
            logic [PW-1:0] offset;
            assign offset      = PW'(gi) - rptr_reg;
            assign hit_vec[gi] = ({1'b0, offset} < level_reg) &&
                                 (addr_mem[gi] == Q_ADDR);
        end
    endgenerate

    assign Q_HIT    = |hit_vec;
    assign RF_WE    = (level_reg != '0);
    assign RF_ADDR  = addr_mem[rptr_reg];
    assign RF_DATA  = data_mem[rptr_reg];
    assign LEVEL    = level_reg;
    assign IN_STALL = (level_reg > LW'(DEPTH - 2));
    assign OVERFLOW = overflow_reg;

endmodule

// File: doc/mtsp_wb_collector.md
Name: mtsp_wb_collector

Overview:
- Receiving end of the EX-stage dual-phase result interface (DEST0/WMASK0, DEST1/WMASK1).
- Per cycle, it accepts up to two write-back results, one from phase #0 and one from phase #1. It queues them in order and drains them through a single register-file write port that has its own grant.
- Provides upstream back-pressure, a pending-write hazard query for the scoreboard, and a sticky overflow flag.

Parameters:
- DATA_WIDTH, 32, result word width (matches DWORD).
- ADDR_WIDTH, 8, register-file address width.
- DEPTH, 4, queue entries; power of two, >= 2.

Ports:
- CLK  input  1  main clock
- RST  input  1  synchronous reset, active-high
- WMASK0  input  1  phase #0 result valid
- ADDR0  input  ADDR_WIDTH  phase #0 destination register
- DEST0  input  DATA_WIDTH  phase #0 result data
- WMASK1  input  1  phase #1 result valid
- ADDR1  input  ADDR_WIDTH  phase #1 destination register
- DEST1  input  DATA_WIDTH  phase #1 result data
- IN_STALL  output  1  fewer than 2 free entries; upstream must hold
- RF_READY  input  1  register-file port grant
- RF_WE  output  1  head entry valid (write request)
- RF_ADDR  output  ADDR_WIDTH  head entry address
- RF_DATA  output  DATA_WIDTH  head entry data
- LEVEL  output  $clog2(DEPTH)+1  occupied entries
- Q_ADDR  input  ADDR_WIDTH  hazard query address
- Q_HIT  output  1  some queued entry targets Q_ADDR
- OVERFLOW  output  1  sticky: a valid input was dropped

Behaviour:
- Reset (RST=1 at a CLK edge):
  - Read pointer, write pointer, LEVEL and OVERFLOW all go to 0.
  - RF_WE=0, IN_STALL=0, Q_HIT=0.
  - RF_ADDR and RF_DATA read storage and are don't-care while RF_WE=0.
  - Reset mid-drain discards every queued entry; nothing further is written.
- Storage is a circular buffer of DEPTH {addr, data} entries with registered pointers.
- Push count per cycle is WMASK0 + WMASK1 (0..2).
- Ordering:
  - The phase #0 entry is written at wptr and the phase #1 entry after it.
  - A lone phase #1 entry is written at wptr.
  - Program order is therefore phase #0 before phase #1; for the same ADDR the later phase wins at the register file.
- Pop:
  - RF_WE = (LEVEL != 0), driven from registered state only; head is first-word-fall-through at rptr.
  - A pop occurs when RF_WE && RF_READY; rptr advances by 1.
  - At most one pop per cycle.
- Latency: an entry pushed at edge N is presented on RF_WE/RF_ADDR/RF_DATA from cycle N+1. There is no input-to-output bypass.
- Level update: LEVEL_next = LEVEL + pushes - pop. Pointers wrap modulo DEPTH.
- Free space counts a same-cycle pop: free = DEPTH - LEVEL + pop.
- Simultaneous push and pop with LEVEL=DEPTH is legal and accepts 1 entry.
- IN_STALL = (LEVEL > DEPTH-2), decoded from registered LEVEL.
- Writes while IN_STALL=1 are an upstream violation, handled as follows:
  - Entries are accepted in order while free > 0.
  - Excess entries (phase #1 first, then phase #0) are dropped.
  - OVERFLOW is set to 1 and held until reset.
  - Queue contents and order are never corrupted.
- Q_HIT:
  - Combinational OR over the valid entries (indices rptr..rptr+LEVEL-1) of (entry.addr == Q_ADDR).
  - It covers stored entries only; same-cycle inputs are excluded.
  - An entry popping this cycle still counts.
- RF_ADDR and RF_DATA are stable while RF_WE=1 and RF_READY=0.

Test Plan:
- Reset, then a single push with WMASK0=1, ADDR0=0x05, DEST0=0x3F800000 -> next cycle RF_WE=1, RF_ADDR=0x05, RF_DATA=0x3F800000, LEVEL=1; with RF_READY=1 the cycle after shows LEVEL=0, RF_WE=0.
- Dual push (0x01/0xAAAA0000, 0x02/0x0000BBBB) with RF_READY=0 for 3 cycles -> LEVEL=2, IN_STALL=0 (DEPTH=4), head holds 0x01/0xAAAA0000 stable; then RF_READY=1 -> writes drain in order 0x01 then 0x02.
- Two dual pushes back-to-back with RF_READY=0 -> LEVEL=4, IN_STALL=1; a third dual push -> both entries dropped, OVERFLOW=1, LEVEL=4; a later drain outputs exactly the original 4 entries in order.
- LEVEL=4 with RF_READY=1 and WMASK0=1 only -> one pop plus one push, LEVEL stays 4, OVERFLOW stays 0; pointer wrap verified by 12 consecutive sequential values drained in order.
- Queue holds addresses {0x10, 0x11}: Q_ADDR=0x11 -> Q_HIT=1; Q_ADDR=0x12 -> Q_HIT=0; after both entries drain, Q_ADDR=0x11 -> Q_HIT=0.
- RST=1 for one cycle while LEVEL=3 and OVERFLOW=1 -> next cycle LEVEL=0, RF_WE=0, OVERFLOW=0, IN_STALL=0, and no further RF writes.
